// File: rtl/trng_word_assembler.sv
// trng_word_assembler: von Neumann debiased TRNG bits packed into WIDTH-bit words behind a FWFT FIFO
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   raw_bit, raw_valid    raw entropy sample, taken on edges where raw_valid is high
//   out_data, out_valid   FIFO head word; valid while words are buffered and health is good
//   out_ready             consumer accept; pop on out_valid && out_ready
//   fill_level            number of buffered words
//   overflow              sticky; a completed word was dropped on a full FIFO
//   health_fail           sticky; repetition-count test tripped, output path frozen until reset
module trng_word_assembler #(
   parameter int WIDTH      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int RCT_CUTOFF = 32,
   parameter int DEBIAS     = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          raw_bit,
   input  logic                          raw_valid,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          overflow,
   output logic                          health_fail
);
   localparam int CW = $clog2(WIDTH);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   typedef enum logic {FIRST, SECOND} pair_t;
   pair_t            state;
   logic             held;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    rd, wr;
   logic [RW-1:0]    run, run_next;
   logic             last;
   logic             active, emit, emit_val, complete, trip, pop, push, full, do_push;
   logic [WIDTH-1:0] next_word;
   always_comb begin
      active    = raw_valid && !health_fail;
      emit      = active && (DEBIAS == 0 || (state == SECOND && raw_bit != held));
      emit_val  = DEBIAS != 0 ? held : raw_bit;
      next_word = {shift[WIDTH-2:0], emit_val};
      complete  = emit && cnt == CW'(WIDTH - 1);
      // run==0 only right after reset, so the first sample starts a run of 1
      run_next  = (run == '0 || raw_bit != last) ? RW'(1) :
                  (run == RW'(RCT_CUTOFF) ? run : run + RW'(1));
      trip      = active && run_next == RW'(RCT_CUTOFF);
      pop       = out_valid && out_ready;
      push      = complete && !trip;
      full      = fill_level == LW'(FIFO_DEPTH);
      // a full FIFO still accepts a push when the head leaves on the same edge
      do_push   = push && (!full || pop);
   end
   assign out_valid = fill_level != '0 && !health_fail;
   assign out_data  = out_valid ? mem[rd] : '0;
   always_ff @(posedge clk)
      if (!reset && !trip && do_push) mem[wr] <= next_word;
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FIRST;
         held        <= 1'b0;
         cnt         <= '0;
         shift       <= '0;
         run         <= '0;
         last        <= 1'b0;
         rd          <= '0;
         wr          <= '0;
         fill_level  <= '0;
         overflow    <= 1'b0;
         health_fail <= 1'b0;
      end else begin
         if (active) begin
            run  <= run_next;
            last <= raw_bit;
            if (DEBIAS != 0) begin
               state <= state == FIRST ? SECOND : FIRST;
               if (state == FIRST) held <= raw_bit;
            end
         end
         if (emit) begin
            shift <= next_word;
            cnt   <= complete ? '0 : cnt + CW'(1);
         end
         if (trip) begin
            health_fail <= 1'b1;
            rd          <= '0;
            wr          <= '0;
            fill_level  <= '0;
         end else begin
            if (do_push) wr <= wr + PW'(1);
            if (pop) rd <= rd + PW'(1);
            if (push && full && !pop) overflow <= 1'b1;
            fill_level <= fill_level + LW'(do_push) - LW'(pop);
         end
      end
   end
endmodule

// File: tb/tb_trng_word_assembler.sv
// tb_trng_word_assembler: randomized and directed checks of trng_word_assembler against a bit-queue reference model
module tb_trng_word_assembler;
   localparam int CUT = 32;
   logic       clk = 1'b0;
   logic       reset, raw_bit, raw_valid, out_ready;
   logic [7:0] od [2];
   logic       ov [2];
   logic [2:0] fl [2];
   logic       ovf [2];
   logic       hf [2];
   int         n_chk = 0, n_fail = 0;
   bit         chk_en = 1'b0;
   logic [7:0] exp_q [2][$];
   bit         pend [2][$];
   bit         bits [2][$];
   int         m_run [2];
   bit         m_last [2];
   bit         m_hf [2];
   bit         m_ovf [2];
   always #5 clk = ~clk;
   trng_word_assembler #(.WIDTH(8), .FIFO_DEPTH(4), .RCT_CUTOFF(CUT), .DEBIAS(1)) u_deb (
      .clk(clk), .reset(reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
      .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .fill_level(fl[0]), .overflow(ovf[0]), .health_fail(hf[0]));
   trng_word_assembler #(.WIDTH(8), .FIFO_DEPTH(4), .RCT_CUTOFF(CUT), .DEBIAS(0)) u_raw (
      .clk(clk), .reset(reset), .raw_bit(raw_bit), .raw_valid(raw_valid),
      .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .fill_level(fl[1]), .overflow(ovf[1]), .health_fail(hf[1]));
   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endfunction
   // monitor: state of the previous edge vs model, pops the scoreboard on each handshake
   always @(negedge clk) if (chk_en) for (int k = 0; k < 2; k++) begin
      chk($sformatf("fill_level[%0d]", k), 32'(fl[k]), 32'(exp_q[k].size()));
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(exp_q[k].size() != 0));
      chk($sformatf("overflow[%0d]", k), 32'(ovf[k]), 32'(m_ovf[k]));
      chk($sformatf("health_fail[%0d]", k), 32'(hf[k]), 32'(m_hf[k]));
      if (ov[k] === 1'b1 && out_ready) begin
         if (exp_q[k].size() == 0) chk($sformatf("unexpected_word[%0d]", k), 32'(od[k]), 32'hdead);
         else chk($sformatf("out_data[%0d]", k), 32'(od[k]), 32'(exp_q[k].pop_front()));
      end
   end
   // reference model: predicts the effect of the coming edge, after the monitor's pop
   always @(negedge clk) begin
      #1;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            exp_q[k].delete(); pend[k].delete(); bits[k].delete();
            m_run[k] = 0; m_last[k] = 1'b0; m_hf[k] = 1'b0; m_ovf[k] = 1'b0;
         end else if (raw_valid && !m_hf[k]) begin
            m_run[k] = (m_run[k] == 0 || raw_bit != m_last[k]) ? 1 : m_run[k] + 1;
            m_last[k] = raw_bit;
            if (m_run[k] >= CUT) begin
               m_hf[k] = 1'b1;
               exp_q[k].delete();
            end else begin
               if (k == 1) bits[k].push_back(raw_bit);
               else begin
                  pend[k].push_back(raw_bit);
                  if (pend[k].size() == 2) begin
                     if (pend[k][0] != pend[k][1]) bits[k].push_back(pend[k][0]);
                     pend[k].delete();
                  end
               end
               if (bits[k].size() == 8) begin
                  logic [7:0] w = '0;
                  foreach (bits[k][i]) w = {w[6:0], bits[k][i]};
                  bits[k].delete();
                  if (exp_q[k].size() < 4) exp_q[k].push_back(w);
                  else m_ovf[k] = 1'b1;
               end
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic smp(input bit b);
      raw_valid = 1'b1; raw_bit = b; tick();
   endtask
   task automatic idle(input int n);
      raw_valid = 1'b0; repeat (n) tick();
   endtask
   task automatic do_reset();
      reset = 1'b1; tick(); reset = 1'b0;
   endtask
   task automatic send_bit(input bit b);
      smp(b); smp(!b);
   endtask
   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask
   initial begin
      logic [7:0] seq;
      reset = 1'b1; raw_valid = 1'b0; raw_bit = 1'b0; out_ready = 1'b1;
      tick();
      chk_en = 1'b1; reset = 1'b0;
      chk("reset_out_valid", 32'(ov[0]), 0);
      chk("reset_fill", 32'(fl[0]), 0);
      // debiased word appears for exactly one cycle right after the 16th sample
      send_word(8'hB2);
      raw_valid = 1'b0;
      chk("t1_valid", 32'(ov[0]), 1);
      chk("t1_data", 32'(od[0]), 32'hB2);
      tick();
      chk("t1_valid_one_cycle", 32'(ov[0]), 0);
      // equal pairs are discarded
      for (int i = 0; i < 30; i++) smp(i[1]);
      idle(1);
      chk("t2_fill", 32'(fl[0]), 0);
      chk("t2_health", 32'(hf[0]), 0);
      // overflow: fifth word dropped, first four drain in order
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_word(8'(i));
      idle(1);
      chk("t3_fill", 32'(fl[0]), 4);
      chk("t3_overflow", 32'(ovf[0]), 1);
      out_ready = 1'b1;
      idle(6);
      chk("t3_drained", 32'(fl[0]), 0);
      // repetition count trips on exactly the 32nd identical sample and flushes
      do_reset();
      out_ready = 1'b0;
      send_word(8'hA5);
      for (int i = 0; i < 31; i++) smp(1'b1);
      chk("t4_no_trip_31", 32'(hf[0]), 0);
      smp(1'b1);
      raw_valid = 1'b0;
      chk("t4_trip_32", 32'(hf[0]), 1);
      chk("t4_flush_fill", 32'(fl[0]), 0);
      chk("t4_flush_valid", 32'(ov[0]), 0);
      out_ready = 1'b1;
      send_word(8'h3C);
      idle(2);
      chk("t4_frozen", 32'(fl[0]), 0);
      do_reset();
      for (int i = 0; i < 31; i++) smp(1'b1);
      smp(1'b0);
      raw_valid = 1'b0;
      chk("t4_31_then_0", 32'(hf[0]), 0);
      // reset discards partially assembled bits
      do_reset();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      do_reset();
      send_word(8'h5A);
      raw_valid = 1'b0;
      chk("t5_data", 32'(od[0]), 32'h5A);
      idle(2);
      // DEBIAS=0 instance packs raw samples directly
      do_reset();
      seq = 8'hB2;
      for (int i = 7; i >= 0; i--) smp(seq[i]);
      raw_valid = 1'b0;
      chk("t6_valid", 32'(ov[1]), 1);
      chk("t6_data", 32'(od[1]), 32'hB2);
      idle(2);
      // randomized segments, some heavily biased to exercise the health test
      for (int s = 0; s < 9; s++) begin
         int bias = (s % 3 == 2) ? 93 : 50;
         do_reset();
         repeat (300) begin
            raw_valid = $urandom_range(99) < 70;
            raw_bit   = $urandom_range(99) < bias;
            out_ready = $urandom_range(99) < 60;
            if ($urandom_range(399) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
         end
      end
      out_ready = 1'b1;
      idle(8);
      chk("drain_deb", 32'(exp_q[0].size()), 0);
      chk("drain_raw", 32'(exp_q[1].size()), 0);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
